// File: rtl/mii_pkg.sv
// Shared FSM state type, line-code symbols and CRC constants for the MII/RMII receive path.
package mii_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2,
    DROP     = 2'd3
  } rx_state_t;

  localparam logic [1:0] PRE_SYM_RMII = 2'b01;
  localparam logic [1:0] SFD_SYM_RMII = 2'b11;
  localparam logic [3:0] PRE_SYM_MII  = 4'h5;
  localparam logic [3:0] SFD_SYM_MII  = 4'hD;

  // Reflected Ethernet polynomial; the residue is the finalised (complemented)
  // CRC of an intact destination..FCS stream.
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE   = 32'h2144DF1C;

  // Byte idx of a station address in wire order (idx 0 = addr[47:40]).
  function automatic logic [7:0] addr_byte(input logic [47:0] addr, input int idx);
    logic [47:0] sh;
    sh = addr >> (8 * (5 - idx));
    return sh[7:0];
  endfunction

endpackage

// File: rtl/crc32.sv
// Ethernet CRC-32, LSB-first, advancing MII_W bits per enabled cycle.
module crc32
  import mii_pkg::*;
#(
  parameter int MII_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             en,
  input  logic [MII_W-1:0] din,
  output logic [31:0]      crc_out
);

  logic [31:0] crc_reg;
  logic [31:0] stage [0:MII_W];

  assign stage[0] = crc_reg;

  for (genvar gi = 0; gi < MII_W; gi++) begin : g_bit
    assign stage[gi+1] = (stage[gi] >> 1) ^
                         ((stage[gi][0] ^ din[gi]) ? CRC_POLY_REFL : 32'h0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_reg <= '1;
    end else if (init) begin
      crc_reg <= '1;
    end else if (en) begin
      crc_reg <= stage[MII_W];
    end
  end

  assign crc_out = ~crc_reg;

endmodule

// File: rtl/mii_rx_frame.sv
// MII/RMII receive framer: SFD hunt, byte assembly, address/length/alignment/CRC checks.
// Define MII_RX_FRAME_BCAST_EN to also accept destination FF:FF:FF:FF:FF:FF.
module mii_rx_frame
  import mii_pkg::*;
#(
  parameter int          MII_W    = 2,
  parameter logic [47:0] MAC_ADDR = 48'h00183E03E2DC,
  parameter int          MIN_LEN  = 64,
  parameter int          MAX_LEN  = 1518
) (
  input  logic             eth_clk,
  input  logic             rst_n,
  input  logic [MII_W-1:0] eth_rx,
  input  logic             eth_dv,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_sof,
  output logic             rx_eof,
  output logic             rx_good,
  output logic [10:0]      rx_len,
  output logic [3:0]       rx_stat
);

  localparam int SYMS  = 8 / MII_W;
  localparam int CNT_W = (MII_W == 4) ? 1 : 2;
  localparam logic [MII_W-1:0] PRE_SYM =
    (MII_W == 4) ? MII_W'(PRE_SYM_MII) : MII_W'(PRE_SYM_RMII);
  localparam logic [MII_W-1:0] SFD_SYM =
    (MII_W == 4) ? MII_W'(SFD_SYM_MII) : MII_W'(SFD_SYM_RMII);

  rx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] sym_cnt_reg, sym_cnt_next;
  logic [7-MII_W:0] part_reg, part_next;
  logic [10:0]      byte_cnt_reg, byte_cnt_next;
  logic             mac_miss_reg, mac_miss_next;
  logic             first_reg;

  logic [7:0]  data_next;
  logic        valid_next, sof_next, eof_next, good_next;
  logic [10:0] len_next;
  logic [3:0]  stat_next;

  logic [7:0]  byte_full;
  logic        in_payload, frame_start, byte_done, over_len, addr_slot;
  logic [10:0] cnt_inc;
  logic        dest_miss, addr_miss, crc_err;
  logic [31:0] crc_out;

  assign in_payload  = (state_reg == PAYLOAD);
  assign frame_start = (state_reg == PREAMBLE) && eth_dv && (eth_rx == SFD_SYM);
  assign byte_full   = {eth_rx, part_reg};
  assign byte_done   = in_payload && eth_dv && (sym_cnt_reg == CNT_W'(SYMS - 1));
  assign over_len    = byte_done && (byte_cnt_reg >= 11'(MAX_LEN));
  assign cnt_inc     = (byte_cnt_reg == 11'h7FF) ? byte_cnt_reg : byte_cnt_reg + 11'd1;
  assign addr_slot   = byte_done && (byte_cnt_reg < 11'd6);
  assign crc_err     = (crc_out != CRC_RESIDUE);

  crc32 #(
    .MII_W (MII_W)
  ) u_crc (
    .clk     (eth_clk),
    .rst_n   (rst_n),
    .init    (!in_payload),
    .en      (in_payload && eth_dv),
    .din     (eth_rx),
    .crc_out (crc_out)
  );

  always_comb begin
    mac_miss_next = mac_miss_reg;
    if (frame_start) begin
      mac_miss_next = 1'b0;
    end else if (addr_slot && (byte_full != addr_byte(MAC_ADDR, int'(byte_cnt_reg)))) begin
      mac_miss_next = 1'b1;
    end
  end

`ifdef MII_RX_FRAME_BCAST_EN
  logic bcast_miss_reg;

  always_ff @(posedge eth_clk or negedge rst_n) begin
    if (!rst_n) begin
      bcast_miss_reg <= 1'b0;
    end else if (frame_start) begin
      bcast_miss_reg <= 1'b0;
    end else if (addr_slot && (byte_full != 8'hFF)) begin
      bcast_miss_reg <= 1'b1;
    end
  end

  assign dest_miss = mac_miss_reg && bcast_miss_reg;
`else
  assign dest_miss = mac_miss_reg;
`endif

  // A frame that ends before the whole destination arrived cannot match.
  assign addr_miss = dest_miss || (byte_cnt_reg < 11'd6);

  always_comb begin
    state_next    = state_reg;
    sym_cnt_next  = sym_cnt_reg;
    part_next     = part_reg;
    byte_cnt_next = byte_cnt_reg;
    data_next     = rx_data;
    valid_next    = 1'b0;
    sof_next      = 1'b0;
    eof_next      = 1'b0;
    good_next     = rx_good;
    len_next      = rx_len;
    stat_next     = rx_stat;

    case (state_reg)
      IDLE: begin
        if (eth_dv) begin
          state_next = (first_reg || (eth_rx != PRE_SYM)) ? DROP : PREAMBLE;
        end
      end

      PREAMBLE: begin
        if (!eth_dv) begin
          state_next = IDLE;
        end else if (eth_rx == SFD_SYM) begin
          state_next    = PAYLOAD;
          sym_cnt_next  = '0;
          byte_cnt_next = '0;
        end else if (eth_rx != PRE_SYM) begin
          state_next = DROP;
        end
      end

      PAYLOAD: begin
        if (!eth_dv) begin
          state_next = IDLE;
          eof_next   = 1'b1;
          len_next   = byte_cnt_reg;
          stat_next  = {crc_err, (sym_cnt_reg != '0),
                        (byte_cnt_reg < 11'(MIN_LEN)), addr_miss};
          good_next  = (stat_next == 4'b0000);
        end else begin
          part_next    = byte_full[7:MII_W];
          sym_cnt_next = byte_done ? '0 : sym_cnt_reg + 1'b1;
          if (byte_done) begin
            byte_cnt_next = cnt_inc;
            if (over_len) begin
              // Oversized: report now and discard the rest of the frame.
              state_next = DROP;
              eof_next   = 1'b1;
              len_next   = cnt_inc;
              stat_next  = {1'b0, 1'b0, 1'b1, addr_miss};
              good_next  = 1'b0;
            end else begin
              data_next  = byte_full;
              valid_next = 1'b1;
              sof_next   = (byte_cnt_reg == 11'd0);
            end
          end
        end
      end

      default: begin
        if (!eth_dv) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge eth_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      sym_cnt_reg  <= '0;
      part_reg     <= '0;
      byte_cnt_reg <= '0;
      mac_miss_reg <= 1'b0;
      first_reg    <= 1'b1;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_sof       <= 1'b0;
      rx_eof       <= 1'b0;
      rx_good      <= 1'b0;
      rx_len       <= '0;
      rx_stat      <= '0;
    end else begin
      state_reg    <= state_next;
      sym_cnt_reg  <= sym_cnt_next;
      part_reg     <= part_next;
      byte_cnt_reg <= byte_cnt_next;
      mac_miss_reg <= mac_miss_next;
      first_reg    <= 1'b0;
      rx_data      <= data_next;
      rx_valid     <= valid_next;
      rx_sof       <= sof_next;
      rx_eof       <= eof_next;
      rx_good      <= good_next;
      rx_len       <= len_next;
      rx_stat      <= stat_next;
    end
  end

endmodule
